mul_cpu_control_fsm: RTL

Multi-cycle CPU control unit: a state machine that sequences the datapath through IF/ID/EXE/MEM/WB for every instruction. It drives all write enables and mux selects, including `ALUM2Reg` and `WrRegData` to the write-back latch/mux stage. It also keeps a retired-instruction counter for CPI measurement. It sits between the instruction register (opcode, ALU zero flag) and the PC, instruction memory, register file, ALU and data memory.

---
 rtl/mul_cpu_control_fsm_if.sv | 35 +++
 rtl/mul_cpu_control_fsm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mul_cpu_control_fsm_if.sv
// Control bus between the multi-cycle control FSM and the datapath.
// The FSM side (master) reads the IR opcode and ALU zero flag and drives
// every enable/select; the datapath side (slave) sees the reverse view.
interface mul_cpu_control_fsm_if #(
  parameter int OPW = 6
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           PCWre;
  logic           IRWre;
  logic           InsMemRW;
  logic           RegWre;
  logic [1:0]     RegDst;
  logic           ALUSrcB;
  logic           ExtSel;
  logic [2:0]     ALUOp;
  logic           DataMemRW;
  logic           ALUM2Reg;
  logic           WrRegData;
  logic [1:0]     PCSrc;
  logic [2:0]     state;
  logic [31:0]    InsCount;

  modport master (
    input  opcode, zero,
    output PCWre, IRWre, InsMemRW, RegWre, RegDst, ALUSrcB, ExtSel, ALUOp,
           DataMemRW, ALUM2Reg, WrRegData, PCSrc, state, InsCount
  );

  modport slave (
    output opcode, zero,
    input  PCWre, IRWre, InsMemRW, RegWre, RegDst, ALUSrcB, ExtSel, ALUOp,
           DataMemRW, ALUM2Reg, WrRegData, PCSrc, state, InsCount
  );
endinterface

// File: rtl/mul_cpu_control_fsm.sv
// Multi-cycle CPU control unit: sequences IF/ID/EXE/MEM/WB per instruction,
// decodes all datapath enables/selects, and counts retired instructions.
module mul_cpu_control_fsm #(
  parameter int OPW = 6
) (
  input  logic                        CLK,
  input  logic                        Reset,
  mul_cpu_control_fsm_if.master       bus
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6'b010000);
  localparam logic [OPW-1:0] OP_AND  = OPW'(6'b010001);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b010010);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b110000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b110001);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b110100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b111000);
  localparam logic [OPW-1:0] OP_JR   = OPW'(6'b111001);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b111010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

  state_e      state_q, state_d;
  logic        halt_q, halt_d;
  logic [31:0] count_q, count_d;

  logic op_add, op_sub, op_addi, op_or, op_and, op_ori;
  logic op_sw, op_lw, op_beq, op_j, op_jr, op_jal, op_halt;
  logic is_alu;

  logic       pc_wre, ir_wre, reg_wre, alu_src_b, ext_sel;
  logic       dm_rw, alum2reg, wr_reg_data;
  logic [1:0] reg_dst, pc_src;
  logic [2:0] alu_op;

  assign op_add  = (bus.opcode == OP_ADD);
  assign op_sub  = (bus.opcode == OP_SUB);
  assign op_addi = (bus.opcode == OP_ADDI);
  assign op_or   = (bus.opcode == OP_OR);
  assign op_and  = (bus.opcode == OP_AND);
  assign op_ori  = (bus.opcode == OP_ORI);
  assign op_sw   = (bus.opcode == OP_SW);
  assign op_lw   = (bus.opcode == OP_LW);
  assign op_beq  = (bus.opcode == OP_BEQ);
  assign op_j    = (bus.opcode == OP_J);
  assign op_jr   = (bus.opcode == OP_JR);
  assign op_jal  = (bus.opcode == OP_JAL);
  assign op_halt = (bus.opcode == OP_HALT);
  assign is_alu  = op_add | op_sub | op_addi | op_or | op_and | op_ori;

  // Next-state, halt flag, retire counter and all control outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    halt_d      = halt_q;
    pc_wre      = 1'b0;
    ir_wre      = 1'b0;
    reg_wre     = 1'b0;
    reg_dst     = 2'b00;
    alu_src_b   = 1'b0;
    ext_sel     = 1'b1;
    alu_op      = 3'b000;
    dm_rw       = 1'b0;
    alum2reg    = 1'b0;
    wr_reg_data = 1'b1;
    pc_src      = 2'b00;

    // Opcode-qualified selects; the IR is stale during IF, so IF keeps defaults.
    if (state_q != S_IF) begin
      if (op_add || op_sub || op_or || op_and)  reg_dst = 2'b10;
      else if (op_addi || op_ori || op_lw)      reg_dst = 2'b01;
      alu_src_b = op_addi | op_ori | op_lw | op_sw;
      ext_sel   = ~op_ori;
      if (op_sub || op_beq)     alu_op = 3'b001;
      else if (op_or || op_ori) alu_op = 3'b011;
      else if (op_and)          alu_op = 3'b100;
    end

    case (state_q)
      S_IF: begin
        ir_wre  = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (halt_q || op_halt) begin
          // Halt is sticky: park in ID with every write disabled until reset.
          halt_d  = 1'b1;
          state_d = S_ID;
        end else if (is_alu) begin
          state_d = S_EXE_AL;
        end else if (op_beq) begin
          state_d = S_EXE_BR;
        end else if (op_lw || op_sw) begin
          state_d = S_EXE_LS;
        end else begin
          // j / jr / jal / nop all retire in ID.
          state_d = S_IF;
          pc_wre  = 1'b1;
          if (op_jal) begin
            reg_wre     = 1'b1;
            wr_reg_data = 1'b0;
            pc_src      = 2'b11;
          end else if (op_j) begin
            pc_src = 2'b11;
          end else if (op_jr) begin
            pc_src = 2'b10;
          end
        end
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL: begin
        reg_wre = 1'b1;
        pc_wre  = 1'b1;
        state_d = S_IF;
      end
      S_EXE_BR: begin
        pc_wre  = 1'b1;
        pc_src  = bus.zero ? 2'b01 : 2'b00;
        state_d = S_IF;
      end
      S_EXE_LS: state_d = S_MEM;
      S_MEM: begin
        alum2reg = 1'b1;
        if (op_lw) begin
          state_d = S_WB_LD;
        end else begin
          dm_rw   = op_sw;
          pc_wre  = 1'b1;
          state_d = S_IF;
        end
      end
      S_WB_LD: begin
        alum2reg = 1'b1;
        reg_wre  = 1'b1;
        pc_wre   = 1'b1;
        state_d  = S_IF;
      end
      default: state_d = S_IF;
    endcase

    // No architectural write may happen in a reset cycle.
    if (Reset) begin
      pc_wre  = 1'b0;
      reg_wre = 1'b0;
      dm_rw   = 1'b0;
    end

    count_d = count_q + {31'd0, pc_wre};
  end

  // State, halt flag and retire counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      state_q <= S_IF;
      halt_q  <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      count_q <= count_d;
    end
  end

  assign bus.PCWre     = pc_wre;
  assign bus.IRWre     = ir_wre;
  assign bus.InsMemRW  = 1'b1;
  assign bus.RegWre    = reg_wre;
  assign bus.RegDst    = reg_dst;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ExtSel    = ext_sel;
  assign bus.ALUOp     = alu_op;
  assign bus.DataMemRW = dm_rw;
  assign bus.ALUM2Reg  = alum2reg;
  assign bus.WrRegData = wr_reg_data;
  assign bus.PCSrc     = pc_src;
  assign bus.state     = state_q;
  assign bus.InsCount  = count_q;

endmodule
